conv_mac_engine: RTL and testbench

// - Parametrised K x K convolution engine; successor to the per-layer fire expand/squeeze blocks.
// - Consumes a serial ifm tap stream: K*K*CHIN taps per output pixel.
// - Drives DSP_NO parallel MACs with weights from an external ROM, then adds bias, applies ReLU and rescales.
// - Emits DSP_NO output channels per output pixel. A single clock drives all logic; there are no derived sampling clocks.

---
 rtl/conv_mac_engine.sv | 157 +++++++++++++++
 tb/tb_conv_mac_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// K x K convolution engine: serial ifm taps feed DSP_NO parallel MAC lanes, then bias, ReLU and rescale.
// Optional macro CONV_SAT_EN clamps positive results that exceed the WIDTH-bit range.
module conv_mac_engine #(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int KERNEL_DIM = 3,
    parameter int CHIN       = 16,
    parameter int CHOUT      = 64,
    parameter int DSP_NO     = 64,
    parameter int W_OUT      = 64,
    parameter int H_OUT      = 64,
    localparam int TAPS      = KERNEL_DIM * KERNEL_DIM * CHIN,
    localparam int GROUPS    = W_OUT * H_OUT * (CHOUT / DSP_NO),
    localparam int ACC_W     = 2 * WIDTH + $clog2(TAPS),
    localparam int ADDR_W    = $clog2(TAPS * CHOUT / DSP_NO)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [WIDTH-1:0]        ifm,
    input  logic                    ifm_valid,
    output logic                    ifm_ready,
    output logic [ADDR_W-1:0]       w_addr,
    input  logic [WIDTH*DSP_NO-1:0] w_data,
    input  logic [WIDTH*DSP_NO-1:0] bias,
    output logic [WIDTH*DSP_NO-1:0] ofm,
    output logic                    ofm_valid,
    output logic                    layer_end
);

    localparam int NGRP  = CHOUT / DSP_NO;
    localparam int SUM_W = ACC_W + 1;
    localparam int TAP_W = $clog2(TAPS);
    localparam int GRP_W = $clog2(GROUPS + 1);
    localparam int CHG_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, OUT, DONE} state_t;

    state_t                    state, state_next;
    logic [TAP_W-1:0]          tap_cnt;
    logic                      flush_cnt;
    logic [GRP_W-1:0]          group_cnt;
    logic [CHG_W-1:0]          chgrp;
    logic signed [WIDTH-1:0]   ifm_r;
    logic                      s1_valid, s2_valid;
    logic signed [2*WIDTH-1:0] prod [DSP_NO];
    logic signed [ACC_W-1:0]   acc  [DSP_NO];
    logic [WIDTH*DSP_NO-1:0]   ofm_next;
    logic                      accept, last_tap, last_group, last_chgrp, out_fire;

    assign ifm_ready  = (state == ACCUM) && en;
    assign accept     = ifm_valid && ifm_ready;
    assign last_tap   = (tap_cnt == TAP_W'(TAPS - 1));
    assign last_group = (group_cnt == GRP_W'(GROUPS - 1));
    assign last_chgrp = (chgrp == CHG_W'(NGRP - 1));
    assign out_fire   = (state == OUT) && en;
    // Address of the tap about to be accepted, so the ROM word lines up with ifm_r next cycle.
    assign w_addr     = ADDR_W'(chgrp) * ADDR_W'(TAPS) + ADDR_W'(tap_cnt);

    // ReLU, then keep the integer window of the fixed-point sum.
    function automatic logic [WIDTH-1:0] post_scale(input logic signed [SUM_W-1:0] s);
        logic [WIDTH-1:0] r;
        r = s[FRAC+WIDTH-1:FRAC];
        if (s[SUM_W-1]) begin
            r = '0;
        end
`ifdef CONV_SAT_EN
        else if (|s[SUM_W-2:FRAC+WIDTH-1]) begin
            r = {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
`endif
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en) state_next = ACCUM;
            ACCUM:   if (accept && last_tap) state_next = FLUSH;
            FLUSH:   if (en && flush_cnt) state_next = OUT;
            OUT:     if (en) state_next = last_group ? DONE : ACCUM;
            DONE:    if (!en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tap_cnt   <= '0;
            flush_cnt <= 1'b0;
            group_cnt <= '0;
            chgrp     <= '0;
        end else begin
            if (accept) tap_cnt <= last_tap ? '0 : tap_cnt + TAP_W'(1);
            if (state == FLUSH && en) flush_cnt <= ~flush_cnt;
            if (out_fire) begin
                if (last_group) begin
                    group_cnt <= '0;
                    chgrp     <= '0;
                end else begin
                    group_cnt <= group_cnt + GRP_W'(1);
                    chgrp     <= last_chgrp ? '0 : chgrp + CHG_W'(1);
                end
            end
        end
    end

    // The MAC pipeline keeps draining while en is low; only the control path freezes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifm_r    <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            for (int l = 0; l < DSP_NO; l++) begin
                prod[l] <= '0;
                acc[l]  <= '0;
            end
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) ifm_r <= $signed(ifm);
            for (int l = 0; l < DSP_NO; l++) begin
                prod[l] <= (2*WIDTH)'(ifm_r) * (2*WIDTH)'($signed(w_data[l*WIDTH +: WIDTH]));
                if (out_fire)      acc[l] <= '0;
                else if (s2_valid) acc[l] <= acc[l] + ACC_W'(prod[l]);
            end
        end
    end

    always_comb begin
        ofm_next = '0;
        for (int l = 0; l < DSP_NO; l++) begin
            ofm_next[l*WIDTH +: WIDTH] = post_scale(SUM_W'(acc[l]) +
                (SUM_W'($signed(bias[l*WIDTH +: WIDTH])) <<< FRAC));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofm       <= '0;
            ofm_valid <= 1'b0;
            layer_end <= 1'b0;
        end else begin
            ofm_valid <= out_fire;
            if (out_fire) ofm <= ofm_next;
            if (out_fire && last_group)  layer_end <= 1'b1;
            else if (state == DONE && !en) layer_end <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Scoreboard bench for conv_mac_engine: a driver feeds taps and pushes reference results,
// a monitor pops and compares on every ofm_valid pulse.
module tb_conv_mac_engine;

    localparam int WIDTH     = 16;
    localparam int FRAC      = 8;
    localparam int KDIM      = 3;
    localparam int CHIN      = 16;
    localparam int CHOUT     = 8;
    localparam int DSP_NO    = 4;
    localparam int W_OUT     = 2;
    localparam int H_OUT     = 2;
    localparam int TAPS      = KDIM * KDIM * CHIN;
    localparam int NGRP      = CHOUT / DSP_NO;
    localparam int GROUPS    = W_OUT * H_OUT * NGRP;
    localparam int ROM_DEPTH = TAPS * NGRP;
    localparam int ADDR_W    = $clog2(ROM_DEPTH);
    localparam int VW        = WIDTH * DSP_NO;

    logic              clk;
    logic              rst;
    logic              en;
    logic [WIDTH-1:0]  ifm;
    logic              ifm_valid;
    logic              ifm_ready;
    logic [ADDR_W-1:0] w_addr;
    logic [VW-1:0]     w_data;
    logic [VW-1:0]     bias;
    logic [VW-1:0]     ofm;
    logic              ofm_valid;
    logic              layer_end;

    typedef struct {
        logic [VW-1:0] data;
        bit            last;
        longint        acc_edge;
    } exp_t;

    exp_t          sb_q [$];
    logic [VW-1:0] rom [ROM_DEPTH];
    logic [VW-1:0] bias_tab [NGRP];
    longint        acc_m [DSP_NO];
    int            k_m;
    int            g_m;
    longint        cyc;
    int            pulse_cnt;
    int            n_checks;
    int            n_fail;

    conv_mac_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .KERNEL_DIM(KDIM), .CHIN(CHIN),
        .CHOUT(CHOUT), .DSP_NO(DSP_NO), .W_OUT(W_OUT), .H_OUT(H_OUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .ifm(ifm), .ifm_valid(ifm_valid),
        .ifm_ready(ifm_ready), .w_addr(w_addr), .w_data(w_data), .bias(bias),
        .ofm(ofm), .ofm_valid(ofm_valid), .layer_end(layer_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Weight ROM with one cycle of read latency
    always @(posedge clk) w_data <= rom[w_addr];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h required=%h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Fixed-point result of one lane from the exact integer dot product
    function automatic logic [WIDTH-1:0] ref_out(input longint dot, input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] bs;
        longint s, q;
        bs = b;
        s  = dot + longint'(bs) * (longint'(1) << FRAC);
        if (s < 0) return '0;
        q = s / (longint'(1) << FRAC);
`ifdef CONV_SAT_EN
        if (q > (longint'(1) << (WIDTH - 1)) - 1) return {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return q[WIDTH-1:0];
    endfunction

    task automatic model_accept(input logic [WIDTH-1:0] val);
        int                      chg, addr;
        logic [VW-1:0]           wv;
        logic [VW-1:0]           bv;
        logic signed [WIDTH-1:0] wl, vs;
        exp_t                    e;
        chg  = g_m % NGRP;
        addr = chg * TAPS + k_m;
        checkOutput("w_addr", 64'(w_addr), 64'(addr));
        if (k_m == 0) bias = bias_tab[chg];
        wv = rom[addr];
        vs = val;
        for (int l = 0; l < DSP_NO; l++) begin
            wl = wv[l*WIDTH +: WIDTH];
            acc_m[l] += longint'(vs) * longint'(wl);
        end
        k_m++;
        if (k_m == TAPS) begin
            bv = bias_tab[chg];
            for (int l = 0; l < DSP_NO; l++) begin
                e.data[l*WIDTH +: WIDTH] = ref_out(acc_m[l], bv[l*WIDTH +: WIDTH]);
                acc_m[l] = 0;
            end
            e.last     = (g_m == GROUPS - 1);
            e.acc_edge = cyc + 1;
            sb_q.push_back(e);
            k_m = 0;
            g_m = (g_m + 1) % GROUPS;
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] val, input bit jitter);
        int waited;
        bit done;
        waited = 0;
        done   = 0;
        while (!done) begin
            @(negedge clk);
            ifm       = val;
            ifm_valid = jitter ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (ifm_valid && ifm_ready) begin
                model_accept(val);
                done = 1;
            end else begin
                waited++;
                if (waited > 100) begin
                    checkOutput("tap_timeout", 64'(waited), 64'd100);
                    done = 1;
                end
            end
        end
    endtask

    task automatic stall_en();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            en        = 1'b0;
            ifm_valid = 1'($urandom_range(0, 1));
            #1;
            checkOutput("stall_ready", 64'(ifm_ready), 64'd0);
            checkOutput("stall_w_addr", 64'(w_addr), 64'((g_m % NGRP) * TAPS + k_m));
        end
        en = 1'b1;
    endtask

    task automatic load_rom(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1, input bit rnd);
        logic [VW-1:0] word;
        for (int a = 0; a < ROM_DEPTH; a++) begin
            for (int l = 0; l < DSP_NO; l++) begin
                word[l*WIDTH +: WIDTH] = rnd ? WIDTH'($urandom) : ((a / TAPS == 0) ? w0 : w1);
            end
            rom[a] = word;
        end
    endtask

    task automatic run_layer(input string name, input bit rnd, input logic [WIDTH-1:0] cval,
                             input bit jitter, input bit stall);
        logic [WIDTH-1:0] v;
        int waited;
        $display("[TB] layer %s", name);
        pulse_cnt = 0;
        @(negedge clk);
        en = 1'b1;
        for (int g = 0; g < GROUPS; g++) begin
            for (int k = 0; k < TAPS; k++) begin
                if (stall && g == 3 && k == 70) stall_en();
                v = rnd ? WIDTH'($urandom) : cval;
                applyStimulus(v, jitter);
            end
        end
        @(negedge clk);
        ifm_valid = 1'b0;
        waited = 0;
        while (sb_q.size() != 0 && waited < 50) begin
            @(negedge clk);
            #2;
            waited++;
        end
        checkOutput("drain", 64'(sb_q.size()), 64'd0);
        checkOutput("pulse_count", 64'(pulse_cnt), 64'(GROUPS));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ifm_valid = 1'b1;
            en        = 1'b1;
            #1;
            checkOutput("done_ready", 64'(ifm_ready), 64'd0);
            checkOutput("done_layer_end", 64'(layer_end), 64'd1);
        end
        @(negedge clk);
        ifm_valid = 1'b0;
        en        = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("layer_end_clear", 64'(layer_end), 64'd0);
        checkOutput("idle_w_addr", 64'(w_addr), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && ofm_valid) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_ofm_valid", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                checkOutput("ofm", 64'(ofm), 64'(e.data));
                checkOutput("pulse_layer_end", 64'(layer_end), 64'(e.last));
                checkOutput("latency", 64'(cyc - e.acc_edge), 64'd3);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        pulse_cnt = 0;
        k_m       = 0;
        g_m       = 0;
        for (int l = 0; l < DSP_NO; l++) acc_m[l] = 0;
        rst       = 1'b1;
        en        = 1'b0;
        ifm       = '0;
        ifm_valid = 1'b0;
        bias      = '0;
        load_rom(16'h0100, 16'h0100, 1'b0);
        #2 rst = 1'b0;

        @(negedge clk);
        #1;
        checkOutput("reset_ofm", 64'(ofm), 64'd0);
        checkOutput("reset_ofm_valid", 64'(ofm_valid), 64'd0);
        checkOutput("reset_layer_end", 64'(layer_end), 64'd0);
        checkOutput("reset_ready", 64'(ifm_ready), 64'd0);
        checkOutput("reset_w_addr", 64'(w_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < NGRP; c++) bias_tab[c] = '0;
        run_layer("unit_mac", 1'b0, 16'h0100, 1'b0, 1'b0);

        $display("[TB] reset mid-accumulation");
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 50; k++) applyStimulus(16'h0100, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        ifm_valid = 1'b0;
        en        = 1'b0;
        #1;
        checkOutput("midrst_ofm", 64'(ofm), 64'd0);
        checkOutput("midrst_ofm_valid", 64'(ofm_valid), 64'd0);
        checkOutput("midrst_layer_end", 64'(layer_end), 64'd0);
        checkOutput("midrst_ready", 64'(ifm_ready), 64'd0);
        checkOutput("midrst_w_addr", 64'(w_addr), 64'd0);
        k_m = 0;
        g_m = 0;
        for (int l = 0; l < DSP_NO; l++) acc_m[l] = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("postrst_w_addr", 64'(w_addr), 64'd0);
        checkOutput("postrst_ofm_valid", 64'(ofm_valid), 64'd0);

        load_rom(16'hFF00, 16'h0000, 1'b0);
        for (int c = 0; c < NGRP; c++) bias_tab[c] = {DSP_NO{16'h0080}};
        run_layer("relu_bias", 1'b0, 16'h0100, 1'b0, 1'b0);

        load_rom(16'h7FFF, 16'h7FFF, 1'b0);
        for (int c = 0; c < NGRP; c++) bias_tab[c] = '0;
        run_layer("overflow", 1'b0, 16'h7FFF, 1'b0, 1'b0);

        load_rom(16'h0000, 16'h0000, 1'b1);
        for (int c = 0; c < NGRP; c++) begin
            for (int l = 0; l < DSP_NO; l++) bias_tab[c][l*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        run_layer("random_stall", 1'b1, 16'h0000, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
